alu_reservation_station: RTL

Holds ALU-class instructions (OP, OP-IMM, branch) from dispatch until both operands are available. Snoops the ALU and LSB result broadcasts to wake up waiting operands. Issues at most one ready instruction per cycle to the ALU on its rob_id/valid/op/instr_type/op_other/v1/v2 interface. Sits between the dispatcher/decoder and the ALU.

---
 rtl/alu_reservation_station_pkg.sv | 20 ++
 rtl/alu_reservation_station_rs_priority_enc.sv | 25 ++
 rtl/alu_reservation_station.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_reservation_station_pkg.sv
// Shared constants and types for the ALU reservation station.
//   RS_SIZE_DEFAULT        : default number of station entries
//   ROB_SIZE_WIDTH_DEFAULT : default width of a ROB tag
//   OPC_*                  : RV32I opcodes of the instruction classes held here
//   operand_t              : an operand value with its "still pending" flag
package alu_reservation_station_pkg;

  localparam int RS_SIZE_DEFAULT        = 8;
  localparam int ROB_SIZE_WIDTH_DEFAULT = 4;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic        busy;
    logic [31:0] val;
  } operand_t;

endpackage

// File: rtl/alu_reservation_station_rs_priority_enc.sv
// Lowest-set-bit priority encoder.
//   req   : request vector
//   idx   : index of the lowest set bit of req (0 when none set)
//   found : at least one bit of req is set
module rs_priority_enc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         req,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     found
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = i[$clog2(WIDTH)-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers OP / OP-IMM / branch instructions until
// both operands are known, snooping the ALU and LSB result broadcasts, and
// hands at most one ready instruction per cycle to the ALU.
//   clk, rst (async, active-low), rdy (global enable), clear (flush)
//   issue_*  : new instruction from dispatch; full = no free entry
//   alu_bc_*, lsb_bc_* : result broadcasts used for wake-up and bypass
//   alu_*    : registered dispatch to the ALU, alu_valid is a 1-cycle strobe
module alu_reservation_station
  import alu_reservation_station_pkg::*;
#(
  parameter int RS_SIZE        = RS_SIZE_DEFAULT,
  parameter int ROB_SIZE_WIDTH = ROB_SIZE_WIDTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      clear,
  input  logic                      issue_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
  input  logic [2:0]                issue_op,
  input  logic [6:0]                issue_instr_type,
  input  logic                      issue_op_other,
  input  logic [31:0]               issue_vj,
  input  logic [31:0]               issue_vk,
  input  logic                      issue_qj_busy,
  input  logic                      issue_qk_busy,
  input  logic [ROB_SIZE_WIDTH-1:0] issue_qj,
  input  logic [ROB_SIZE_WIDTH-1:0] issue_qk,
  output logic                      full,
  input  logic                      alu_bc_ready,
  input  logic [ROB_SIZE_WIDTH-1:0] alu_bc_rob_id,
  input  logic [31:0]               alu_bc_result,
  input  logic                      lsb_bc_ready,
  input  logic [ROB_SIZE_WIDTH-1:0] lsb_bc_rob_id,
  input  logic [31:0]               lsb_bc_result,
  output logic                      alu_valid,
  output logic [ROB_SIZE_WIDTH-1:0] alu_rob_id,
  output logic [2:0]                alu_op,
  output logic [6:0]                alu_instr_type,
  output logic                      alu_op_other,
  output logic [31:0]               alu_v1,
  output logic [31:0]               alu_v2
);

  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]        busy_q, busy_d;
  logic [RS_SIZE-1:0]        qj_busy_q, qj_busy_d;
  logic [RS_SIZE-1:0]        qk_busy_q, qk_busy_d;
  logic [RS_SIZE-1:0]        op_other_q, op_other_d;
  logic [ROB_SIZE_WIDTH-1:0] rob_id_q [RS_SIZE];
  logic [ROB_SIZE_WIDTH-1:0] rob_id_d [RS_SIZE];
  logic [ROB_SIZE_WIDTH-1:0] qj_q [RS_SIZE];
  logic [ROB_SIZE_WIDTH-1:0] qj_d [RS_SIZE];
  logic [ROB_SIZE_WIDTH-1:0] qk_q [RS_SIZE];
  logic [ROB_SIZE_WIDTH-1:0] qk_d [RS_SIZE];
  logic [2:0]                op_q [RS_SIZE];
  logic [2:0]                op_d [RS_SIZE];
  logic [6:0]                type_q [RS_SIZE];
  logic [6:0]                type_d [RS_SIZE];
  logic [31:0]               vj_q [RS_SIZE];
  logic [31:0]               vj_d [RS_SIZE];
  logic [31:0]               vk_q [RS_SIZE];
  logic [31:0]               vk_d [RS_SIZE];

  logic                      alu_valid_q, alu_valid_d;
  logic [ROB_SIZE_WIDTH-1:0] alu_rob_id_q, alu_rob_id_d;
  logic [2:0]                alu_op_q, alu_op_d;
  logic [6:0]                alu_type_q, alu_type_d;
  logic                      alu_other_q, alu_other_d;
  logic [31:0]               alu_v1_q, alu_v1_d;
  logic [31:0]               alu_v2_q, alu_v2_d;

  logic [IDX_W-1:0] free_idx, sel_idx;
  logic             free_found, sel_found;
  logic [RS_SIZE-1:0] ready_vec;

  assign full      = &busy_q;
  assign ready_vec = busy_q & ~qj_busy_q & ~qk_busy_q;

  rs_priority_enc #(.WIDTH(RS_SIZE)) u_free_enc (
    .req(~busy_q), .idx(free_idx), .found(free_found)
  );

  rs_priority_enc #(.WIDTH(RS_SIZE)) u_ready_enc (
    .req(ready_vec), .idx(sel_idx), .found(sel_found)
  );

  // Resolve a pending operand against both broadcast ports. Used both for
  // wake-up of stored entries and for bypass of an incoming instruction.
  function automatic operand_t snoop(input logic pend,
                                     input logic [ROB_SIZE_WIDTH-1:0] tag,
                                     input logic [31:0] val);
    operand_t r;
    r.busy = pend;
    r.val  = val;
    if (pend && alu_bc_ready && tag == alu_bc_rob_id) begin
      r.busy = 1'b0;
      r.val  = alu_bc_result;
    end else if (pend && lsb_bc_ready && tag == lsb_bc_rob_id) begin
      r.busy = 1'b0;
      r.val  = lsb_bc_result;
    end
    return r;
  endfunction

  always_comb begin
    busy_d       = busy_q;
    qj_busy_d    = qj_busy_q;
    qk_busy_d    = qk_busy_q;
    op_other_d   = op_other_q;
    rob_id_d     = rob_id_q;
    qj_d         = qj_q;
    qk_d         = qk_q;
    op_d         = op_q;
    type_d       = type_q;
    vj_d         = vj_q;
    vk_d         = vk_q;
    alu_valid_d  = alu_valid_q;
    alu_rob_id_d = alu_rob_id_q;
    alu_op_d     = alu_op_q;
    alu_type_d   = alu_type_q;
    alu_other_d  = alu_other_q;
    alu_v1_d     = alu_v1_q;
    alu_v2_d     = alu_v2_q;

    if (clear) begin
      busy_d      = '0;
      alu_valid_d = 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        {qj_busy_d[i], vj_d[i]} = snoop(busy_q[i] & qj_busy_q[i], qj_q[i], vj_q[i]);
        {qk_busy_d[i], vk_d[i]} = snoop(busy_q[i] & qk_busy_q[i], qk_q[i], vk_q[i]);
        // Keep the pending flag of idle entries untouched.
        if (!busy_q[i]) begin
          qj_busy_d[i] = qj_busy_q[i];
          qk_busy_d[i] = qk_busy_q[i];
        end
      end

      // Selection uses registered state, so a value woken on this edge
      // is only seen by the selector one cycle later.
      alu_valid_d = sel_found;
      if (sel_found) begin
        alu_rob_id_d     = rob_id_q[sel_idx];
        alu_op_d         = op_q[sel_idx];
        alu_type_d       = type_q[sel_idx];
        alu_other_d      = op_other_q[sel_idx];
        alu_v1_d         = vj_q[sel_idx];
        alu_v2_d         = vk_q[sel_idx];
        busy_d[sel_idx]  = 1'b0;
      end

      // The free slot comes from registered busy bits, so it can never be
      // the entry being dispatched on this same edge.
      if (issue_valid && !full && free_found) begin
        busy_d[free_idx]     = 1'b1;
        rob_id_d[free_idx]   = issue_rob_id;
        op_d[free_idx]       = issue_op;
        type_d[free_idx]     = issue_instr_type;
        op_other_d[free_idx] = issue_op_other;
        qj_d[free_idx]       = issue_qj;
        qk_d[free_idx]       = issue_qk;
        {qj_busy_d[free_idx], vj_d[free_idx]} = snoop(issue_qj_busy, issue_qj, issue_vj);
        {qk_busy_d[free_idx], vk_d[free_idx]} = snoop(issue_qk_busy, issue_qk, issue_vk);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q       <= '0;
      qj_busy_q    <= '0;
      qk_busy_q    <= '0;
      op_other_q   <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        rob_id_q[i] <= '0;
        qj_q[i]     <= '0;
        qk_q[i]     <= '0;
        op_q[i]     <= '0;
        type_q[i]   <= '0;
        vj_q[i]     <= '0;
        vk_q[i]     <= '0;
      end
      alu_valid_q  <= 1'b0;
      alu_rob_id_q <= '0;
      alu_op_q     <= '0;
      alu_type_q   <= '0;
      alu_other_q  <= 1'b0;
      alu_v1_q     <= '0;
      alu_v2_q     <= '0;
    end else if (rdy) begin
      busy_q       <= busy_d;
      qj_busy_q    <= qj_busy_d;
      qk_busy_q    <= qk_busy_d;
      op_other_q   <= op_other_d;
      rob_id_q     <= rob_id_d;
      qj_q         <= qj_d;
      qk_q         <= qk_d;
      op_q         <= op_d;
      type_q       <= type_d;
      vj_q         <= vj_d;
      vk_q         <= vk_d;
      alu_valid_q  <= alu_valid_d;
      alu_rob_id_q <= alu_rob_id_d;
      alu_op_q     <= alu_op_d;
      alu_type_q   <= alu_type_d;
      alu_other_q  <= alu_other_d;
      alu_v1_q     <= alu_v1_d;
      alu_v2_q     <= alu_v2_d;
    end
  end

  assign alu_valid      = alu_valid_q;
  assign alu_rob_id     = alu_rob_id_q;
  assign alu_op         = alu_op_q;
  assign alu_instr_type = alu_type_q;
  assign alu_op_other   = alu_other_q;
  assign alu_v1         = alu_v1_q;
  assign alu_v2         = alu_v2_q;

endmodule
